bullet_ctrl: RTL and testbench
==============================

BULLET_CTRL -- requirements
Module: bullet_ctrl

Interface
REQ-001 Parameters SHALL be: COLOR_BITS, 24, total RGB width; SPEED, 4, pixels moved per frame; BSIZE, 4, bullet square side in pixels; EXPLODE_FRAMES, 8, explosion duration in frames.
REQ-002 clk_i  in  1  system clock; one clock, all state on its rising edge.
REQ-003 reset_i  in  1  asynchronous, active-high reset.
REQ-004 frame_tick_i  in  1  one-cycle pulse once per frame, outside the active display.
REQ-005 fire_i  in  1  level fire request from the tank controller.
REQ-006 tank_x_i, tank_y_i  in  10 each  tank upper-left corner; the tank is 32x32.
REQ-007 tank_dir_i  in  2  tank heading: 00 up, 01 right, 10 down, 11 left.
REQ-008 hpos_i, vpos_i, display_enable_i  in  10, 10, 1  raster position and active-video flag.
REQ-009 all_hard_block_i  in  1  map flag: the current pixel is a bullet-stopping block or outside the map.
REQ-010 bullet_collide_o  out  1  drives the map's bullet_collide_i, combinational and valid in the same cycle as hpos_i/vpos_i.
REQ-011 bullet_enable_o  out  1  the current pixel belongs to the drawn bullet or explosion.
REQ-012 bullet_red_o, bullet_green_o, bullet_blue_o  out  COLOR_BITS/3 each  pixel colour.
REQ-013 active_o  out  1  high while the state is not IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, FLYING and EXPLODE.
REQ-015 In IDLE, fire_i=1 SHALL cause the next state to be FLYING, with bx=tank_x_i+14, by=tank_y_i+14 and dir=tank_dir_i latched on that edge.
REQ-016 fire_i SHALL be ignored in FLYING and EXPLODE; each fire is a new acceptance in IDLE with no edge detection.
REQ-017 If fire_i and frame_tick_i are both high in IDLE, the fire SHALL be accepted and no move SHALL occur on that tick.
REQ-018 in_box SHALL be (hpos_i-bx)<BSIZE and (vpos_i-by)<BSIZE, using unsigned 10-bit wrap arithmetic.
REQ-019 bullet_collide_o SHALL equal (state==FLYING) && display_enable_i && in_box && all_hard_block_i.
REQ-020 In FLYING, any cycle with bullet_collide_o=1 SHALL set a registered hit flag; frame_tick_i SHALL clear it.
REQ-021 On frame_tick_i in FLYING with the hit flag clear, the bullet SHALL move SPEED pixels in dir: up by-=SPEED, right bx+=SPEED, down by+=SPEED, left bx-=SPEED.
REQ-022 On frame_tick_i in FLYING with the hit flag set, the next state SHALL be EXPLODE, the position SHALL hold and the frame counter SHALL load 0.
REQ-023 In EXPLODE, each frame_tick_i SHALL increment the counter; the tick on which it equals EXPLODE_FRAMES-1 SHALL return the FSM to IDLE.
REQ-024 The move arithmetic SHALL be 10-bit; the map border reports hard, so the bullet always stops before wrap-around.
REQ-025 bullet_enable_o in FLYING SHALL be display_enable_i && in_box; the colour SHALL be white (all channel bits 1).
REQ-026 bullet_enable_o in EXPLODE SHALL cover the 8x8 box with corner (bx-2, by-2); the colour SHALL be red=max, green=max/2, blue=0.
REQ-027 When bullet_enable_o=0, all colour outputs SHALL be 0.
REQ-028 bullet_collide_o SHALL be 0 in IDLE and EXPLODE.

Reset
REQ-029 reset_i SHALL force state=IDLE, bx=by=0, dir=00, hit flag=0 and counter=0, asynchronously, including mid-flight or mid-explosion.
REQ-030 During and after reset all outputs SHALL be 0 until a fire is accepted.

Structure
REQ-031 The direction encoding (dir_t) and block-type constants BRICK/WALL/TREE/WATER/AIR SHALL live in a shared package, tank_pkg, shared with the map block.
REQ-032 The state enum SHALL be local to bullet_ctrl.
REQ-033 One sub-module, pixel_in_box (position, origin, size in; hit out), SHALL be instantiated twice: once for the bullet box and once for the explosion box.

Verification
REQ-034 Reset, then fire with tank at (64,64), dir=01 -> bullet at (78,78); after 3 frame ticks bx=90, by=78; active_o=1.
REQ-035 A brick at map cell (2,1) (pixels 96..127 x, 64..95 y), bullet flying right at by=78 -> bullet_collide_o pulses during the frame where bx reaches 94, then EXPLODE on the next tick, holding bx=94.
REQ-036 EXPLODE -> exactly 8 frame ticks to IDLE; orange 8x8 box at (92,76) drawn each frame; fire_i held high throughout has no effect until IDLE.
REQ-037 Bullet heading up from tank (32,32) -> collides with the border (all_hard_block_i high at vpos<32) and enters EXPLODE; by never wraps.
REQ-038 fire_i and frame_tick_i high together in IDLE -> spawn at the tank centre with no move that tick.
REQ-039 reset_i asserted mid-flight between clock edges -> state immediately IDLE and all outputs 0.

Source files
------------

// File: rtl/tank_pkg.sv
// Shared definitions for the tank game blocks: heading encoding and map
// block types. The map block and the bullet controller both import this.
package tank_pkg;

    // Tank / bullet heading as driven on tank_dir_i.
    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_t;

    // Map cell contents.
    localparam logic [2:0] BRICK = 3'd0;
    localparam logic [2:0] WALL  = 3'd1;
    localparam logic [2:0] TREE  = 3'd2;
    localparam logic [2:0] WATER = 3'd3;
    localparam logic [2:0] AIR   = 3'd4;

    // Tanks are 32x32; a 4x4 bullet starts at offset 14 so it sits in the centre.
    localparam int unsigned TANK_SIZE       = 32;
    localparam logic [9:0]  TANK_CENTRE_OFS = 10'd14;

endpackage

// File: rtl/pixel_in_box.sv
// Square hit test: is (pos_x, pos_y) inside the size x size box whose upper-left
// corner is (org_x, org_y)? Subtraction wraps in 10 bits, so a position left of
// or above the origin becomes a large value and fails the compare.
module pixel_in_box (
    input  logic [9:0] pos_x_i,
    input  logic [9:0] pos_y_i,
    input  logic [9:0] org_x_i,
    input  logic [9:0] org_y_i,
    input  logic [9:0] size_i,
    output logic       hit_o
);

    logic [9:0] dx;
    logic [9:0] dy;

    // Offset from the box origin and bounds test on both axes.
    always_comb begin
        dx    = pos_x_i - org_x_i;
        dy    = pos_y_i - org_y_i;
        hit_o = (dx < size_i) && (dy < size_i);
    end

endmodule

// File: rtl/bullet_ctrl.sv
// Single-bullet controller: spawns at the tank centre on fire, moves once per
// frame along the latched heading, explodes for EXPLODE_FRAMES frames after it
// touches a hard block, and draws itself into the raster.
// The dbg_* outputs expose state and position for observation only.
module bullet_ctrl
    import tank_pkg::*;
#(
    parameter int COLOR_BITS     = 24,
    parameter int SPEED          = 4,
    parameter int BSIZE          = 4,
    parameter int EXPLODE_FRAMES = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    frame_tick_i,
    input  logic                    fire_i,
    input  logic [9:0]              tank_x_i,
    input  logic [9:0]              tank_y_i,
    input  logic [1:0]              tank_dir_i,
    input  logic [9:0]              hpos_i,
    input  logic [9:0]              vpos_i,
    input  logic                    display_enable_i,
    input  logic                    all_hard_block_i,
    output logic                    bullet_collide_o,
    output logic                    bullet_enable_o,
    output logic [COLOR_BITS/3-1:0] bullet_red_o,
    output logic [COLOR_BITS/3-1:0] bullet_green_o,
    output logic [COLOR_BITS/3-1:0] bullet_blue_o,
    output logic                    active_o,
    output logic [1:0]              dbg_state_o,
    output logic [9:0]              dbg_bx_o,
    output logic [9:0]              dbg_by_o
);

    localparam int CH    = COLOR_BITS / 3;
    localparam int CNT_W = (EXPLODE_FRAMES > 1) ? $clog2(EXPLODE_FRAMES) : 1;

    localparam logic [9:0]       SPEED_V    = 10'(SPEED);
    localparam logic [9:0]       BSIZE_V    = 10'(BSIZE);
    localparam logic [9:0]       EXP_SIZE   = 10'd8;
    localparam logic [9:0]       EXP_OFS    = 10'd2;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(EXPLODE_FRAMES - 1);
    localparam logic [CH-1:0]    COLOUR_MAX = '1;
    localparam logic [CH-1:0]    COLOUR_HALF = COLOUR_MAX >> 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FLYING  = 2'd1,
        S_EXPLODE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [9:0]       bx_q, bx_d;
    logic [9:0]       by_q, by_d;
    dir_t             dir_q, dir_d;
    logic             hit_q, hit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             in_box;
    logic             in_exp_box;
    logic [9:0]       exp_x;
    logic [9:0]       exp_y;
    logic             collide;

    // Explosion is drawn 2 pixels up-left of the bullet so it is centred on it.
    always_comb begin
        exp_x = bx_q - EXP_OFS;
        exp_y = by_q - EXP_OFS;
    end

    pixel_in_box u_bullet_box (
        .pos_x_i (hpos_i),
        .pos_y_i (vpos_i),
        .org_x_i (bx_q),
        .org_y_i (by_q),
        .size_i  (BSIZE_V),
        .hit_o   (in_box)
    );

    pixel_in_box u_explode_box (
        .pos_x_i (hpos_i),
        .pos_y_i (vpos_i),
        .org_x_i (exp_x),
        .org_y_i (exp_y),
        .size_i  (EXP_SIZE),
        .hit_o   (in_exp_box)
    );

    // Collision is purely combinational so the map sees it on the same pixel.
    always_comb begin
        collide = (state_q == S_FLYING) && display_enable_i && in_box && all_hard_block_i;
    end

    // State, position, heading, hit flag and explosion counter.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            bx_q    <= '0;
            by_q    <= '0;
            dir_q   <= DIR_UP;
            hit_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            dir_q   <= dir_d;
            hit_q   <= hit_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. A hit seen anywhere in a frame is acted on at the next
    // frame tick, so the bullet never moves into the block it touched.
    always_comb begin
        state_d = state_q;
        bx_d    = bx_q;
        by_d    = by_q;
        dir_d   = dir_q;
        hit_d   = hit_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                // Fire wins over a coincident frame tick: spawn only, no move.
                if (fire_i) begin
                    state_d = S_FLYING;
                    bx_d    = tank_x_i + TANK_CENTRE_OFS;
                    by_d    = tank_y_i + TANK_CENTRE_OFS;
                    dir_d   = dir_t'(tank_dir_i);
                    hit_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_FLYING: begin
                if (frame_tick_i) begin
                    hit_d = 1'b0;
                    if (hit_q) begin
                        state_d = S_EXPLODE;
                        cnt_d   = '0;
                    end else begin
                        case (dir_q)
                            DIR_UP:    by_d = by_q - SPEED_V;
                            DIR_RIGHT: bx_d = bx_q + SPEED_V;
                            DIR_DOWN:  by_d = by_q + SPEED_V;
                            default:   bx_d = bx_q - SPEED_V;
                        endcase
                    end
                end else if (collide) begin
                    hit_d = 1'b1;
                end
            end
            S_EXPLODE: begin
                if (frame_tick_i) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pixel output: white bullet while flying, orange square while exploding.
    always_comb begin
        bullet_enable_o = 1'b0;
        bullet_red_o    = '0;
        bullet_green_o  = '0;
        bullet_blue_o   = '0;
        case (state_q)
            S_FLYING: begin
                if (display_enable_i && in_box) begin
                    bullet_enable_o = 1'b1;
                    bullet_red_o    = COLOUR_MAX;
                    bullet_green_o  = COLOUR_MAX;
                    bullet_blue_o   = COLOUR_MAX;
                end
            end
            S_EXPLODE: begin
                if (display_enable_i && in_exp_box) begin
                    bullet_enable_o = 1'b1;
                    bullet_red_o    = COLOUR_MAX;
                    bullet_green_o  = COLOUR_HALF;
                end
            end
            default: begin
            end
        endcase
    end

    // Status and debug visibility.
    always_comb begin
        bullet_collide_o = collide;
        active_o         = (state_q != S_IDLE);
        dbg_state_o      = state_q;
        dbg_bx_o         = bx_q;
        dbg_by_o         = by_q;
    end

endmodule

// File: tb/tb_bullet_ctrl.sv
module tb_bullet_ctrl;

    localparam int CB = 24;
    localparam int CH = CB / 3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FLYING  = 2'd1;
    localparam logic [1:0] ST_EXPLODE = 2'd2;

    // map modes: 0 empty, 1 brick at cell (2,1), 2 top border, 3 everything hard
    logic [1:0] map_mode;

    logic          clk;
    logic          rst;
    logic          frame_tick;
    logic          fire;
    logic [9:0]    tank_x;
    logic [9:0]    tank_y;
    logic [1:0]    tank_dir;
    logic [9:0]    hpos;
    logic [9:0]    vpos;
    logic          de;
    logic          all_hard;
    logic          collide;
    logic          en;
    logic [CH-1:0] red;
    logic [CH-1:0] green;
    logic [CH-1:0] blue;
    logic          active;
    logic [1:0]    dbg_state;
    logic [9:0]    dbg_bx;
    logic [9:0]    dbg_by;

    int total;
    int bad;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic map_hard(input logic [1:0] mode, input logic [9:0] h, input logic [9:0] v);
        case (mode)
            2'd1:    return (h >= 10'd96) && (h <= 10'd127) && (v >= 10'd64) && (v <= 10'd95);
            2'd2:    return (v < 10'd32);
            2'd3:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign all_hard = map_hard(map_mode, hpos, vpos);

    bullet_ctrl #(
        .COLOR_BITS     (CB),
        .SPEED          (4),
        .BSIZE          (4),
        .EXPLODE_FRAMES (8)
    ) dut (
        .clk_i            (clk),
        .reset_i          (rst),
        .frame_tick_i     (frame_tick),
        .fire_i           (fire),
        .tank_x_i         (tank_x),
        .tank_y_i         (tank_y),
        .tank_dir_i       (tank_dir),
        .hpos_i           (hpos),
        .vpos_i           (vpos),
        .display_enable_i (de),
        .all_hard_block_i (all_hard),
        .bullet_collide_o (collide),
        .bullet_enable_o  (en),
        .bullet_red_o     (red),
        .bullet_green_o   (green),
        .bullet_blue_o    (blue),
        .active_o         (active),
        .dbg_state_o      (dbg_state),
        .dbg_bx_o         (dbg_bx),
        .dbg_by_o         (dbg_by)
    );

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        fire = 1'b0; frame_tick = 1'b0; de = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic do_fire(input logic [9:0] x, input logic [9:0] y, input logic [1:0] d);
        @(posedge clk);
        #1 tank_x = x; tank_y = y; tank_dir = d; fire = 1'b1;
        @(posedge clk);
        #1 fire = 1'b0;
    endtask

    task automatic do_tick();
        @(posedge clk);
        #1 de = 1'b0; frame_tick = 1'b1;
        @(posedge clk);
        #1 frame_tick = 1'b0;
    endtask

    // Check the {state, bx, by, active} snapshot against hand-computed values.
    task automatic check_pos(input string name, input logic [1:0] es, input logic [9:0] ebx,
                             input logic [9:0] eby, input logic eact);
        logic [22:0] obs;
        logic [22:0] exp_v;
        obs   = {dbg_state, dbg_bx, dbg_by, active};
        exp_v = {es, ebx, eby, eact};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got state=%0d bx=%0d by=%0d act=%0b, want state=%0d bx=%0d by=%0d act=%0b",
                     name, dbg_state, dbg_bx, dbg_by, active, es, ebx, eby, eact);
        end
    endtask

    // Raster a window with display enable high and compare every pixel's
    // enable/collide/colour against the expected bullet or explosion box.
    task automatic scan(input string name, input int x0, input int y0, input int w, input int h,
                        input logic [1:0] es, input logic [9:0] ebx, input logic [9:0] eby);
        int         nbad;
        logic [25:0] obs;
        logic [25:0] exp_v;
        logic [25:0] first_obs;
        logic [25:0] first_exp;
        logic [9:0] dx, dy, ex, ey;
        logic       e_en, e_col;
        nbad = 0;
        first_obs = '0;
        first_exp = '0;
        for (int y = y0; y < y0 + h; y++) begin
            for (int x = x0; x < x0 + w; x++) begin
                @(posedge clk);
                #1 hpos = 10'(x); vpos = 10'(y); de = 1'b1;
                @(negedge clk);
                dx = hpos - ebx;
                dy = vpos - eby;
                ex = hpos - (ebx - 10'd2);
                ey = vpos - (eby - 10'd2);
                e_en  = 1'b0;
                e_col = 1'b0;
                exp_v = '0;
                if (es == ST_FLYING) begin
                    e_en  = (dx < 10'd4) && (dy < 10'd4);
                    e_col = e_en && map_hard(map_mode, hpos, vpos);
                    exp_v = {e_en, e_col, e_en ? 24'hFFFFFF : 24'h000000};
                end else if (es == ST_EXPLODE) begin
                    e_en  = (ex < 10'd8) && (ey < 10'd8);
                    exp_v = {e_en, 1'b0, e_en ? 24'hFF7F00 : 24'h000000};
                end
                obs = {en, collide, red, green, blue};
                if (obs !== exp_v) begin
                    if (nbad == 0) begin
                        first_obs = obs;
                        first_exp = exp_v;
                    end
                    nbad++;
                end
            end
        end
        @(posedge clk);
        #1 de = 1'b0;
        total++;
        if (nbad != 0) begin
            bad++;
            $display("FAIL %s: %0d bad pixels, first got {en,col,rgb}=%h want %h",
                     name, nbad, first_obs, first_exp);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        map_mode = 2'd3;
        hpos = 10'd0; vpos = 10'd0; de = 1'b1;
        #1;
        total++;
        if ({en, collide, red, green, blue, active} !== 27'd0) begin
            bad++;
            $display("FAIL reset_outputs: got en=%0b col=%0b rgb=%h act=%0b, want all 0",
                     en, collide, {red, green, blue}, active);
        end
        check_pos("reset_state", ST_IDLE, 10'd0, 10'd0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if ({en, collide, red, green, blue, active} !== 27'd0) begin
            bad++;
            $display("FAIL idle_outputs: got en=%0b col=%0b rgb=%h act=%0b, want all 0",
                     en, collide, {red, green, blue}, active);
        end
        de = 1'b0;
    endtask

    task automatic test_fire_right();
        map_mode = 2'd0;
        do_fire(10'd64, 10'd64, 2'b01);
        check_pos("spawn_right", ST_FLYING, 10'd78, 10'd78, 1'b1);
        scan("draw_spawn", 74, 74, 12, 12, ST_FLYING, 10'd78, 10'd78);
        for (int i = 0; i < 3; i++) do_tick();
        check_pos("move_3_ticks", ST_FLYING, 10'd90, 10'd78, 1'b1);
    endtask

    task automatic test_brick_hit();
        map_mode = 2'd1;
        scan("no_hit_at_90", 88, 76, 8, 8, ST_FLYING, 10'd90, 10'd78);
        do_tick();
        check_pos("reach_94", ST_FLYING, 10'd94, 10'd78, 1'b1);
        scan("hit_at_94", 92, 76, 8, 8, ST_FLYING, 10'd94, 10'd78);
        do_tick();
        check_pos("enter_explode", ST_EXPLODE, 10'd94, 10'd78, 1'b1);
    endtask

    task automatic test_explode();
        @(posedge clk);
        #1 fire = 1'b1; tank_x = 10'd10; tank_y = 10'd20; tank_dir = 2'b10;
        for (int f = 0; f < 8; f++) begin
            scan($sformatf("explode_draw_%0d", f), 88, 72, 16, 16, ST_EXPLODE, 10'd94, 10'd78);
            do_tick();
            if (f < 7) check_pos($sformatf("explode_hold_%0d", f), ST_EXPLODE, 10'd94, 10'd78, 1'b1);
        end
        check_pos("explode_done", ST_IDLE, 10'd94, 10'd78, 1'b0);
        @(posedge clk);
        #1 fire = 1'b0;
        check_pos("fire_after_idle", ST_FLYING, 10'd24, 10'd34, 1'b1);
    endtask

    task automatic test_border_up();
        logic [9:0] eby;
        do_reset();
        map_mode = 2'd2;
        do_fire(10'd32, 10'd32, 2'b00);
        check_pos("spawn_up", ST_FLYING, 10'd46, 10'd46, 1'b1);
        eby = 10'd46;
        for (int i = 0; i < 5; i++) begin
            scan($sformatf("up_frame_%0d", i), 44, int'(eby) - 2, 8, 8, ST_FLYING, 10'd46, eby);
            do_tick();
            if (i < 4) eby = eby - 10'd4;
        end
        check_pos("border_explode", ST_EXPLODE, 10'd46, 10'd30, 1'b1);
        scan("border_explode_draw", 40, 24, 16, 16, ST_EXPLODE, 10'd46, 10'd30);
    endtask

    task automatic test_back_to_back();
        do_reset();
        map_mode = 2'd0;
        @(posedge clk);
        #1 tank_x = 10'd100; tank_y = 10'd200; tank_dir = 2'b10; fire = 1'b1; frame_tick = 1'b1;
        @(posedge clk);
        #1 fire = 1'b0; frame_tick = 1'b0;
        check_pos("fire_with_tick", ST_FLYING, 10'd114, 10'd214, 1'b1);
        do_tick();
        check_pos("move_down", ST_FLYING, 10'd114, 10'd218, 1'b1);
        do_reset();
        do_fire(10'd200, 10'd100, 2'b11);
        do_tick();
        check_pos("move_left", ST_FLYING, 10'd210, 10'd114, 1'b1);
    endtask

    task automatic test_async_reset();
        do_reset();
        do_fire(10'd64, 10'd64, 2'b01);
        map_mode = 2'd3;
        hpos = 10'd79; vpos = 10'd79; de = 1'b1;
        @(negedge clk);
        total++;
        if ({en, collide} !== 2'b11) begin
            bad++;
            $display("FAIL pre_reset_hit: got en=%0b col=%0b, want 1 1", en, collide);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({en, collide, red, green, blue, active} !== 27'd0) begin
            bad++;
            $display("FAIL async_reset_outputs: got en=%0b col=%0b rgb=%h act=%0b, want all 0",
                     en, collide, {red, green, blue}, active);
        end
        check_pos("async_reset_state", ST_IDLE, 10'd0, 10'd0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        de = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        fire = 1'b0;
        frame_tick = 1'b0;
        tank_x = '0; tank_y = '0; tank_dir = '0;
        hpos = '0; vpos = '0; de = 1'b0;
        map_mode = 2'd0;
        test_reset();
        test_fire_right();
        test_brick_hit();
        test_explode();
        test_border_up();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
